// File: rtl/abacus_pkg.sv
// abacus_pkg: shared ABACUS register map constants and sweeper types.
// Imported by the counter sweeper and its interface.
package abacus_pkg;

   localparam logic [31:0] ABACUS_BASE_DEF  = 32'hf003_0000;
   localparam logic [15:0] ABACUS_IU_OFFSET = 16'h0100;
   localparam logic [15:0] ABACUS_CU_OFFSET = 16'h0200;
   localparam int          ABACUS_IDX_W     = 5;

   typedef enum logic [1:0] {
      SW_IDLE,
      SW_REQ,
      SW_PUSH,
      SW_DONE
   } sweep_state_e;

endpackage

// File: rtl/abacus_counter_sweeper_if.sv
// abacus_counter_sweeper_if: Wishbone classic read bus plus the
// valid/ready sample stream leaving the sweeper.
interface abacus_counter_sweeper_if;
   import abacus_pkg::*;

   logic                    wb_cyc;
   logic                    wb_stb;
   logic                    wb_we;
   logic [31:0]             wb_adr;
   logic [31:0]             wb_dat_o;
   logic [31:0]             wb_dat_i;
   logic                    wb_ack;

   logic                    sample_valid;
   logic                    sample_ready;
   logic [ABACUS_IDX_W-1:0] sample_index;
   logic [31:0]             sample_data;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
      input  wb_dat_i, wb_ack,
      output sample_valid, sample_index, sample_data,
      input  sample_ready
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
      output wb_dat_i, wb_ack,
      input  sample_valid, sample_index, sample_data,
      output sample_ready
   );

endinterface

// File: rtl/abacus_counter_sweeper.sv
// abacus_counter_sweeper: Wishbone initiator reading a block of ABACUS
// counters, one word per bus cycle. ABACUS_SWEEP_TIMEOUT_EN adds an ack timeout.
module abacus_counter_sweeper
   import abacus_pkg::*;
#(
   parameter logic [31:0] ABACUS_BASE_ADDR = ABACUS_BASE_DEF,
   parameter logic [15:0] SWEEP_OFFSET     = ABACUS_IU_OFFSET,
   parameter int          SWEEP_COUNT      = 11
`ifdef ABACUS_SWEEP_TIMEOUT_EN
   ,
   parameter int          TIMEOUT_CYCLES   = 255
`endif
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy,
   output logic done,
   output logic error,
   abacus_counter_sweeper_if.master bus
);

   localparam logic [ABACUS_IDX_W-1:0] LAST_IDX =
      ABACUS_IDX_W'(SWEEP_COUNT - 1);
   localparam logic [31:0] SWEEP_BASE =
      ABACUS_BASE_ADDR + {16'h0, SWEEP_OFFSET};

   sweep_state_e            state_q;
   sweep_state_e            state_d;
   logic [ABACUS_IDX_W-1:0] idx_q;
   logic [ABACUS_IDX_W-1:0] sidx_q;
   logic [31:0]             sdata_q;
   logic                    start_take;
   logic                    ack_take;
   logic                    push_take;
   logic                    last_word;
   logic                    tmo_hit;

   assign start_take = (state_q == SW_IDLE) && start;
   assign ack_take   = (state_q == SW_REQ) && bus.wb_ack;
   assign push_take  = (state_q == SW_PUSH) && bus.sample_ready;
   assign last_word  = (idx_q == LAST_IDX);

`ifdef ABACUS_SWEEP_TIMEOUT_EN
   logic [15:0] wait_q;
   logic        err_q;

   assign tmo_hit = (state_q == SW_REQ) && !bus.wb_ack &&
                    (wait_q == 16'(TIMEOUT_CYCLES - 1));
   assign error   = err_q;

   // ack wait counter: zero outside REQ, counts unacked REQ cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_q <= '0;
      end else if (state_q != SW_REQ) begin
         wait_q <= '0;
      end else if (!bus.wb_ack) begin
         wait_q <= wait_q + 16'd1;
      end
   end

   // sticky timeout flag, cleared by the next accepted start
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else if (start_take) begin
         err_q <= 1'b0;
      end else if (tmo_hit) begin
         err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign error   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= SW_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SW_IDLE: begin
            if (start) state_d = SW_REQ;
         end
         SW_REQ: begin
            if (bus.wb_ack)   state_d = SW_PUSH;
            else if (tmo_hit) state_d = SW_DONE;
         end
         SW_PUSH: begin
            if (bus.sample_ready)
               state_d = last_word ? SW_DONE : SW_REQ;
         end
         SW_DONE: begin
            state_d = SW_IDLE;
         end
         default: begin
            state_d = SW_IDLE;
         end
      endcase
   end

   // word index: reset by start, stepped after each accepted sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q <= '0;
      end else if (start_take) begin
         idx_q <= '0;
      end else if (push_take && !last_word) begin
         idx_q <= idx_q + 1'b1;
      end
   end

   // sample capture on the acked edge; held stable through PUSH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sidx_q  <= '0;
         sdata_q <= '0;
      end else if (ack_take) begin
         sidx_q  <= idx_q;
         sdata_q <= bus.wb_dat_i;
      end
   end

   assign busy = (state_q != SW_IDLE);
   assign done = (state_q == SW_DONE);

   assign bus.wb_cyc   = (state_q == SW_REQ);
   assign bus.wb_stb   = (state_q == SW_REQ);
   assign bus.wb_we    = 1'b0;
   assign bus.wb_dat_o = 32'h0;
   assign bus.wb_adr   = (state_q == SW_REQ) ?
                         SWEEP_BASE + {25'd0, idx_q, 2'b00} : 32'h0;

   assign bus.sample_valid = (state_q == SW_PUSH);
   assign bus.sample_index = sidx_q;
   assign bus.sample_data  = sdata_q;

endmodule

// File: tb/tb_abacus_counter_sweeper.sv
// tb_abacus_counter_sweeper: directed bench for the counter sweeper
// with two behavioural one-cycle-ack ABACUS slaves.
module tb_abacus_counter_sweeper;
   import abacus_pkg::*;

   logic clk;
   logic rst;
   logic iu_start;
   logic cu_start;
   logic iu_busy, iu_done, iu_error;
   logic cu_busy, cu_done, cu_error;
   logic noack;

   int n_chk;
   int n_fail;

   abacus_counter_sweeper_if iu ();
   abacus_counter_sweeper_if cu ();

   abacus_counter_sweeper #(
`ifdef ABACUS_SWEEP_TIMEOUT_EN
      .TIMEOUT_CYCLES (8)
`endif
   ) dut_iu (
      .clk   (clk),
      .rst   (rst),
      .start (iu_start),
      .busy  (iu_busy),
      .done  (iu_done),
      .error (iu_error),
      .bus   (iu)
   );

   abacus_counter_sweeper #(
      .SWEEP_OFFSET (ABACUS_CU_OFFSET),
      .SWEEP_COUNT  (7)
   ) dut_cu (
      .clk   (clk),
      .rst   (rst),
      .start (cu_start),
      .busy  (cu_busy),
      .done  (cu_done),
      .error (cu_error),
      .bus   (cu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] iu_regs [0:10];
   logic [31:0] cu_regs [0:6];

   initial begin
      iu_regs[0]  = 32'h0000_1a2b;
      iu_regs[1]  = 32'h0000_0007;
      iu_regs[2]  = 32'h0012_3456;
      iu_regs[3]  = 32'hdead_beef;
      iu_regs[4]  = 32'h0000_0001;
      iu_regs[5]  = 32'h8000_0000;
      iu_regs[6]  = 32'h5555_aaaa;
      iu_regs[7]  = 32'h0bad_cafe;
      iu_regs[8]  = 32'hffff_ffff;
      iu_regs[9]  = 32'h0000_0100;
      iu_regs[10] = 32'h7654_3210;
      cu_regs[0]  = 32'h0000_0042;
      cu_regs[1]  = 32'h0001_0000;
      cu_regs[2]  = 32'h00c0_ffee;
      cu_regs[3]  = 32'h0000_0000;
      cu_regs[4]  = 32'h1234_0000;
      cu_regs[5]  = 32'h0000_9999;
      cu_regs[6]  = 32'ha5a5_a5a5;
   end

   function automatic logic [31:0] iu_rd(input logic [31:0] a);
      logic [31:0] o;
      o = a - 32'hf003_0100;
      if (o < 32'd44) return iu_regs[o[5:2]];
      return 32'hbad0_0000 | {16'h0, a[15:0]};
   endfunction

   function automatic logic [31:0] cu_rd(input logic [31:0] a);
      logic [31:0] o;
      o = a - 32'hf003_0200;
      if (o < 32'd28) return cu_regs[o[4:2]];
      return 32'hbad0_0000 | {16'h0, a[15:0]};
   endfunction

   logic        iu_ack, cu_ack;
   logic [31:0] iu_rdat, cu_rdat;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         iu_ack  <= 1'b0;
         iu_rdat <= 32'h0;
         cu_ack  <= 1'b0;
         cu_rdat <= 32'h0;
      end else begin
         iu_ack  <= iu.wb_cyc && iu.wb_stb && !iu_ack && !noack;
         iu_rdat <= iu_rd(iu.wb_adr);
         cu_ack  <= cu.wb_cyc && cu.wb_stb && !cu_ack;
         cu_rdat <= cu_rd(cu.wb_adr);
      end
   end

   assign iu.wb_ack   = iu_ack;
   assign iu.wb_dat_i = iu_rdat;
   assign cu.wb_ack   = cu_ack;
   assign cu.wb_dat_i = cu_rdat;

   logic [4:0]  iu_idx_q [$];
   logic [31:0] iu_dat_q [$];
   logic [31:0] iu_adr_q [$];
   logic [4:0]  cu_idx_q [$];
   logic [31:0] cu_dat_q [$];
   logic [31:0] cu_adr_q [$];
   int iu_busy_n, iu_done_n, iu_cyc_n, cu_done_n;

   initial begin
      iu_busy_n = 0;
      iu_done_n = 0;
      iu_cyc_n  = 0;
      cu_done_n = 0;
   end

   always @(negedge clk) begin
      if (iu_busy) iu_busy_n++;
      if (iu_done) iu_done_n++;
      if (iu.wb_cyc) iu_cyc_n++;
      if (cu_done) cu_done_n++;
      if (iu.wb_cyc && iu.wb_stb && iu.wb_ack)
         iu_adr_q.push_back(iu.wb_adr);
      if (cu.wb_cyc && cu.wb_stb && cu.wb_ack)
         cu_adr_q.push_back(cu.wb_adr);
      if (iu.sample_valid && iu.sample_ready) begin
         iu_idx_q.push_back(iu.sample_index);
         iu_dat_q.push_back(iu.sample_data);
      end
      if (cu.sample_valid && cu.sample_ready) begin
         cu_idx_q.push_back(cu.sample_index);
         cu_dat_q.push_back(cu.sample_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic pulse_iu();
      @(posedge clk); #1 iu_start = 1'b1;
      @(posedge clk); #1 iu_start = 1'b0;
   endtask

   task automatic pulse_cu();
      @(posedge clk); #1 cu_start = 1'b1;
      @(posedge clk); #1 cu_start = 1'b0;
   endtask

   task automatic wait_done(input bit sel_cu, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(sel_cu ? cu_done : iu_done) && n < budget);
      chk("done_seen", 32'(sel_cu ? cu_done : iu_done), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_iu_req(input logic [31:0] adr, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(iu.wb_cyc && iu.wb_adr == adr) && n < budget);
      chk("req_seen", iu.wb_adr, adr);
   endtask

   task automatic chk_iu_sweep(input int q0, input int a0);
      chk("iu_nsamp", 32'(iu_idx_q.size() - q0), 32'd11);
      chk("iu_nadr", 32'(iu_adr_q.size() - a0), 32'd11);
      for (int i = 0; i < 11; i++) begin
         if (q0 + i < iu_idx_q.size()) begin
            chk($sformatf("iu_idx%0d", i), 32'(iu_idx_q[q0 + i]), 32'(i));
            chk($sformatf("iu_dat%0d", i), iu_dat_q[q0 + i], iu_regs[i]);
         end
         if (a0 + i < iu_adr_q.size())
            chk($sformatf("iu_adr%0d", i), iu_adr_q[a0 + i],
                32'hf003_0100 + 32'(4 * i));
      end
   endtask

   int q0, a0, b0, d0, c0;

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b0;
      iu_start = 1'b0;
      cu_start = 1'b0;
      noack = 1'b0;
      iu.sample_ready = 1'b1;
      cu.sample_ready = 1'b1;

      #23;
      chk("rst_busy", 32'(iu_busy), 32'd0);
      chk("rst_done", 32'(iu_done), 32'd0);
      chk("rst_err", 32'(iu_error), 32'd0);
      chk("rst_valid", 32'(iu.sample_valid), 32'd0);
      chk("rst_cyc", 32'(iu.wb_cyc), 32'd0);
      chk("rst_stb", 32'(iu.wb_stb), 32'd0);
      chk("rst_adr", iu.wb_adr, 32'd0);
      chk("rst_sidx", 32'(iu.sample_index), 32'd0);
      chk("rst_sdat", iu.sample_data, 32'd0);
      chk("rst_cu_busy", 32'(cu_busy), 32'd0);
      @(negedge clk); #2 rst = 1'b1;

      // single sweep
      q0 = iu_idx_q.size(); a0 = iu_adr_q.size();
      b0 = iu_busy_n; d0 = iu_done_n;
      pulse_iu();
      @(negedge clk);
      chk("first_cyc", 32'(iu.wb_cyc), 32'd1);
      chk("first_adr", iu.wb_adr, 32'hf003_0100);
      chk("we_zero", 32'(iu.wb_we), 32'd0);
      chk("dat_o_zero", iu.wb_dat_o, 32'd0);
      wait_done(1'b0, 200);
      chk("busy_cycles", 32'(iu_busy_n - b0), 32'd34);
      chk("done_pulses", 32'(iu_done_n - d0), 32'd1);
      chk("err_clean", 32'(iu_error), 32'd0);
      chk_iu_sweep(q0, a0);

      // backpressure at index 3
      q0 = iu_idx_q.size(); a0 = iu_adr_q.size();
      pulse_iu();
      wait_iu_req(32'hf003_010c, 100);
      @(posedge clk); #1 iu.sample_ready = 1'b0;
      for (int n = 0; n < 20 && !iu.sample_valid; n++) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp_valid%0d", k), 32'(iu.sample_valid), 32'd1);
         chk($sformatf("bp_idx%0d", k), 32'(iu.sample_index), 32'd3);
         chk($sformatf("bp_dat%0d", k), iu.sample_data, iu_regs[3]);
         chk($sformatf("bp_cyc%0d", k), 32'(iu.wb_cyc), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1 iu.sample_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_next_cyc", 32'(iu.wb_cyc), 32'd1);
      chk("bp_next_adr", iu.wb_adr, 32'hf003_0110);
      wait_done(1'b0, 200);
      chk_iu_sweep(q0, a0);

      // start while busy and during DONE
      q0 = iu_idx_q.size(); a0 = iu_adr_q.size();
      b0 = iu_busy_n; d0 = iu_done_n;
      pulse_iu();
      for (int n = 0; n < 50 &&
           !(iu.sample_valid && iu.sample_index == 5'd2); n++)
         @(negedge clk);
      @(posedge clk); #1 iu_start = 1'b1;
      @(posedge clk); #1 iu_start = 1'b0;
      for (int n = 0; n < 200 && !iu_done; n++) @(negedge clk);
      chk("sb_in_done", 32'(iu_done), 32'd1);
      iu_start = 1'b1;
      @(posedge clk); #1 iu_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("sb_idle%0d", k), 32'(iu_busy), 32'd0);
      end
      chk("sb_done_pulses", 32'(iu_done_n - d0), 32'd1);
      chk("sb_busy_cycles", 32'(iu_busy_n - b0), 32'd34);
      chk_iu_sweep(q0, a0);

      // cache sweep
      q0 = cu_idx_q.size(); a0 = cu_adr_q.size(); d0 = cu_done_n;
      pulse_cu();
      wait_done(1'b1, 200);
      chk("cu_nsamp", 32'(cu_idx_q.size() - q0), 32'd7);
      chk("cu_nadr", 32'(cu_adr_q.size() - a0), 32'd7);
      chk("cu_done_pulses", 32'(cu_done_n - d0), 32'd1);
      for (int i = 0; i < 7; i++) begin
         if (q0 + i < cu_idx_q.size()) begin
            chk($sformatf("cu_idx%0d", i), 32'(cu_idx_q[q0 + i]), 32'(i));
            chk($sformatf("cu_dat%0d", i), cu_dat_q[q0 + i], cu_regs[i]);
         end
         if (a0 + i < cu_adr_q.size())
            chk($sformatf("cu_adr%0d", i), cu_adr_q[a0 + i],
                32'hf003_0200 + 32'(4 * i));
      end
      if (a0 + 3 < cu_adr_q.size())
         chk("cu_adr3_fixed", cu_adr_q[a0 + 3], 32'hf003_020c);
      if (q0 + 3 < cu_dat_q.size())
         chk("cu_dat3_zero", cu_dat_q[q0 + 3], 32'h0);

`ifdef ABACUS_SWEEP_TIMEOUT_EN
      // ack timeout on index 0
      noack = 1'b1;
      q0 = iu_idx_q.size(); c0 = iu_cyc_n; d0 = iu_done_n;
      pulse_iu();
      wait_done(1'b0, 60);
      chk("tmo_cyc_cycles", 32'(iu_cyc_n - c0), 32'd8);
      chk("tmo_err", 32'(iu_error), 32'd1);
      chk("tmo_nsamp", 32'(iu_idx_q.size() - q0), 32'd0);
      chk("tmo_done", 32'(iu_done_n - d0), 32'd1);
      noack = 1'b0;
      q0 = iu_idx_q.size(); a0 = iu_adr_q.size();
      pulse_iu();
      @(negedge clk);
      chk("tmo_err_clr", 32'(iu_error), 32'd0);
      wait_done(1'b0, 200);
      chk_iu_sweep(q0, a0);
`endif

      // reset mid-sweep at index 5
      pulse_iu();
      wait_iu_req(32'hf003_0114, 100);
      #2 rst = 1'b0;
      #1;
      chk("mr_cyc", 32'(iu.wb_cyc), 32'd0);
      chk("mr_stb", 32'(iu.wb_stb), 32'd0);
      chk("mr_adr", iu.wb_adr, 32'd0);
      chk("mr_busy", 32'(iu_busy), 32'd0);
      chk("mr_done", 32'(iu_done), 32'd0);
      chk("mr_valid", 32'(iu.sample_valid), 32'd0);
      chk("mr_sidx", 32'(iu.sample_index), 32'd0);
      chk("mr_sdat", iu.sample_data, 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      chk("mr_err", 32'(iu_error), 32'd0);
      q0 = iu_idx_q.size(); a0 = iu_adr_q.size(); d0 = iu_done_n;
      pulse_iu();
      wait_done(1'b0, 200);
      chk("mr_done_pulses", 32'(iu_done_n - d0), 32'd1);
      chk_iu_sweep(q0, a0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/abacus_counter_sweeper.md
# abacus_counter_sweeper

Wishbone classic initiator that sweeps a contiguous block of ABACUS profiler counter registers, one single read per word. Each returned word is presented on a valid/ready sample stream tagged with its index. It sits between the ABACUS register slave and an on-chip consumer such as a trace packer or UART dumper, so counter snapshots need no CPU involvement.

## Interface
- ABACUS_BASE_ADDR, 32'hf0030000, base of the ABACUS register map.
- SWEEP_OFFSET, 16'h0100, byte offset of the first register swept; must be 4-byte aligned.
- SWEEP_COUNT, 11, number of 32-bit words per sweep, 1..31.
- TIMEOUT_CYCLES, 255, ack wait limit in clk cycles, 1..65535; used only when ABACUS_SWEEP_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
- busy  out  1  high from the cycle after start is accepted until the cycle done pulses.
- done  out  1  one-cycle pulse when a sweep ends, whether it completed or aborted.
- error  out  1  sticky ack-timeout flag; cleared when the next start is accepted.
- sample_valid  out  1  sample is presented.
- sample_ready  in  1  consumer accepts the sample.
- sample_index  out  5  word index 0..SWEEP_COUNT-1.
- sample_data  out  32  read data.
- wb_cyc, wb_stb, wb_we  out  1 each  bus controls; wb_we is constant 0.
- wb_adr  out  32  ABACUS_BASE_ADDR + SWEEP_OFFSET + 4*index.
- wb_dat_o  out  32  constant 32'h0.
- wb_dat_i  in  32  read data from the slave.
- wb_ack  in  1  acknowledge from the slave.

## Operation
- While rst=0, every output is 0: busy, done, error, sample_valid, sample_index, sample_data, wb_cyc, wb_stb, wb_adr. The state is IDLE and the index is 0.
- States are IDLE, REQ, PUSH and DONE.
- IDLE:
  - When start=1, load index 0, clear error and go to REQ.
  - busy goes to 1 on the same edge.
- REQ:
  - wb_cyc and wb_stb are 1; wb_adr is computed from the current index.
  - On an edge where wb_ack=1, capture wb_dat_i and the index into the sample registers.
  - On that same edge, drive wb_cyc and wb_stb to 0 and go to PUSH.
  - The initiator never holds stb for a second beat, so the slave's ~ack gating cannot produce a double ack.
- PUSH:
  - sample_valid=1; data and index stay stable until the handshake.
  - On an edge with sample_valid=1 and sample_ready=1, drop sample_valid.
  - If index == SWEEP_COUNT-1, go to DONE; otherwise increment the index and go to REQ.
- DONE:
  - done=1 for one cycle, busy goes to 0 and the state returns to IDLE.
  - A start asserted during DONE is ignored.
- Any wb_ack seen outside REQ is ignored.
- A sweep is not an atomic snapshot: counters keep running between reads.
- The index width is 5 bits and is never allowed to wrap. The largest value used is SWEEP_COUNT-1 ≤ 30.

## Timing
- start is sampled at edge E0; wb_cyc=1 during the cycle after E0.
- With a one-cycle-ack slave and sample_ready tied to 1, each word takes 3 cycles: 2 in REQ and 1 in PUSH.
- A full sweep occupies busy for 3*SWEEP_COUNT+1 cycles; done is high in the final one.
- Minimum gap between accepting a start and the next accepted start is 3*SWEEP_COUNT+2 cycles.
- sample_valid rises exactly 1 cycle after the ack edge. wb_cyc falls on the same edge that samples the ack.
- Backpressure: sample_ready=0 holds PUSH indefinitely, with no bus activity and sample fields stable.
- An asynchronous reset mid-sweep drops wb_cyc immediately, with no completion. After release the block returns to IDLE with error=0.

## Configuration
- ABACUS_SWEEP_TIMEOUT_EN defined:
  - A 16-bit wait counter clears on entry to REQ and increments every REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with no ack, wb_cyc and wb_stb drop, error is set and the state goes to DONE.
  - No sample is emitted for the failed word, and the remaining words are skipped.
- ABACUS_SWEEP_TIMEOUT_EN undefined:
  - No counter exists and REQ waits indefinitely.
  - error stays 0 permanently.

## Structure
- Shared package abacus_pkg holds:
  - the ABACUS_BASE_ADDR default;
  - the instruction-unit and cache-unit offset constants (16'h0100, 16'h0200);
  - the sweeper state enum typedef.
- No sub-module is needed. The timeout counter is small enough to stay inline.

## Test plan
- Single sweep: ABACUS slave with instruction profiler enabled, sample_ready=1, start pulse.
  - Expect 11 samples at indices 0..10 and addresses f0030100..f0030128 in steps of 4.
  - Data must match the slave's registers.
  - busy must be high for 34 cycles, with a single done pulse.
- Backpressure: hold sample_ready=0 for 5 cycles at index 3.
  - sample_valid stays 1 with index 3 and data stable, and wb_cyc stays 0.
  - Index 4 is requested 1 cycle after ready rises.
- Start while busy: pulse start at index 2 and again during DONE.
  - Both pulses are ignored; exactly 11 samples are produced and done pulses once.
- Cache sweep: set SWEEP_OFFSET=16'h0200 and SWEEP_COUNT=7, with the cache profiler counting.
  - Index 3 reads address f003020C and returns 0.
- Timeout (macro on, TIMEOUT_CYCLES=8): the slave never acks index 0.
  - wb_cyc drops after 8 REQ cycles, error=1 and done pulses.
  - No sample is produced.
  - The next start clears error.
- Reset mid-sweep: drive rst=0 during REQ at index 5.
  - All outputs are 0 within the same cycle.
  - After release, a new start sweeps cleanly from index 0.
